// File: rtl/fetch_pc_unit.sv
// Purpose : stage-1 PC register and fetch sequencer; one imem request in flight,
//           PC advances by one word (modular), redirects drop stale fetches.
// Latency : reset release -> imem_req 1 cycle; imem_req -> instr_valid 2 cycles
//           (gnt on first REQ cycle, rvalid one cycle later); 1 instr / 3 cycles.
// Backpr. : instr held stable while instr_ready=0; no new request is issued until
//           decode takes it or a redirect discards it. stall=1 masks imem_req.
// Ports   : clk/rst_n; stall; redirect_valid/redirect_addr (word address);
//           imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata (memory side);
//           instr_valid/instr/instr_pc/instr_ready (decode side).
module fetch_pc_unit #(
  parameter int              N        = 30,
  parameter logic [N-1:0]    RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_addr,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [N-1:0] instr_pc,
  input  logic         instr_ready
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [N-1:0] PC_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [N-1:0] pc;
  logic [N-1:0] fetch_pc;  // address of the request currently in flight
  logic         drop;      // in-flight response is stale and must be discarded

  // A grant only counts while the request is actually presented.
  logic gnt_ok;

  assign imem_req  = (state == ST_REQ) && !stall;
  assign gnt_ok    = imem_req && imem_gnt;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_REQ;

        ST_REQ: begin
          if (gnt_ok) begin
            if (redirect_valid) begin
              // Granted request already belongs to the wrong path.
              pc   <= redirect_addr;
              drop <= 1'b1;
            end else begin
              fetch_pc <= pc;
              pc       <= pc + PC_ONE;  // wraps modulo 2^N
            end
            state <= ST_WAIT;
          end else if (redirect_valid) begin
            pc <= redirect_addr;
          end
        end

        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              state <= ST_REQ;
              if (redirect_valid) pc <= redirect_addr;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= fetch_pc;
              instr_valid <= 1'b1;
              state       <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_addr;
            drop <= 1'b1;
          end
        end

        ST_HOLD: begin
          // A redirect alongside instr_ready still completes the transfer;
          // it only chooses the next fetch address.
          if (instr_ready || redirect_valid) begin
            instr_valid <= 1'b0;
            state       <= ST_REQ;
            if (redirect_valid) pc <= redirect_addr;
          end
        end

        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Purpose : self-checking bench for fetch_pc_unit with a behavioural memory
//           responder and a transaction-level model of the fetch stream.
// Latency : n/a (bench).  Backpressure: driven randomly and in directed tests.
module tb_fetch_pc_unit;

  localparam int N = 30;
  localparam logic [N-1:0] RPC = 30'h10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic         redirect_valid;
  logic [N-1:0] redirect_addr;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [N-1:0] instr_pc;
  logic         instr_ready;

  fetch_pc_unit #(.N(N), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder and expected-stream model.
  int           gnt_pct = 100;
  int           lat_min = 1;
  int           lat_max = 1;
  bit           out_valid = 1'b0;   // request outstanding in memory
  bit           out_stale = 1'b0;   // that response must never reach decode
  int           out_cnt   = 0;
  logic [N-1:0] out_addr  = '0;
  logic [N-1:0] exp_pc    = RPC;    // address the next fetch must use
  bit           holding   = 1'b0;   // an instruction should be offered to decode
  logic [N-1:0] exp_ipc   = '0;
  int           cyc       = 0;

  logic [N-1:0] dq_pc[$];
  logic [31:0]  dq_in[$];
  int           dq_cyc[$];

  function automatic logic [31:0] mem_word(input logic [N-1:0] a);
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  // One clock: present memory response, observe handshakes, advance the model.
  task automatic tick();
    bit rv, acc, redir, hs;
    logic [N-1:0] raddr;
    rv          = out_valid && (out_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(out_addr) : $urandom();
    imem_gnt    = !out_valid && (int'($urandom_range(99, 0)) < gnt_pct);
    #1;
    acc   = imem_req && imem_gnt;
    redir = redirect_valid;
    raddr = redirect_addr;
    hs    = instr_valid && instr_ready && rst_n;
    if (hs) begin
      dq_pc.push_back(instr_pc);
      dq_in.push_back(instr);
      dq_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      holding = 1'b0;
      exp_pc  = RPC;
      if (out_valid) begin
        out_stale = 1'b1;
        if (rv) out_valid = 1'b0;
        else    out_cnt--;
      end
    end else begin
      if (holding && (hs || redir)) holding = 1'b0;
      if (rv) begin
        out_valid = 1'b0;
        if (!out_stale && !redir) begin
          holding = 1'b1;
          exp_ipc = out_addr;
        end
      end else if (out_valid) begin
        out_cnt--;
        if (redir) out_stale = 1'b1;
      end
      if (acc) begin
        out_valid = 1'b1;
        out_addr  = exp_pc;
        out_stale = redir;
        out_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
      end
      if (redir)    exp_pc = raddr;
      else if (acc) exp_pc = exp_pc + 30'd1;
    end
    @(negedge clk);
  endtask

  task automatic redirect_once(input logic [N-1:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    instr_ready = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    gnt_pct = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    checks += 5;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
    if (imem_addr !== RPC) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, RPC); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
    if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    if (instr_pc !== '0) begin errors++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
  endtask

  task automatic test_sequential();
    gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready = 1'b1;
    dq_pc.delete(); dq_in.delete(); dq_cyc.delete();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %0b want 0", imem_req); end
    tick();
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %0b want 1", imem_req); end
    tick(); tick();
    checks += 2;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL req_to_valid got %0b want 1", instr_valid); end
    if (instr_pc !== RPC) begin errors++; $display("FAIL first_instr_pc got %h want %h", instr_pc, RPC); end
    for (int i = 0; i < 30 && dq_pc.size() < 3; i++) tick();
    checks++;
    if (dq_pc.size() < 3) begin
      errors++; $display("FAIL seq_timeout got %0d instrs want 3", dq_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (dq_pc[i] !== RPC + 30'(i)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, dq_pc[i], RPC + 30'(i)); end
        if (dq_in[i] !== mem_word(RPC + 30'(i))) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, dq_in[i], mem_word(RPC + 30'(i))); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (dq_cyc[i] - dq_cyc[i-1] != 3) begin errors++; $display("FAIL seq_rate[%0d] got %0d cycles want 3", i, dq_cyc[i] - dq_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_wrap();
    redirect_once(30'h3FFFFFFF);
    dq_pc.delete(); dq_in.delete();
    for (int i = 0; i < 40 && dq_pc.size() < 2; i++) tick();
    checks++;
    if (dq_pc.size() < 2) begin
      errors++; $display("FAIL wrap_timeout got %0d instrs want 2", dq_pc.size());
    end else begin
      checks += 3;
      if (dq_pc[0] !== 30'h3FFFFFFF) begin errors++; $display("FAIL wrap_pc0 got %h want 3fffffff", dq_pc[0]); end
      if (dq_pc[1] !== 30'h0) begin errors++; $display("FAIL wrap_pc1 got %h want 0", dq_pc[1]); end
      if (dq_in[1] !== mem_word(30'h0)) begin errors++; $display("FAIL wrap_instr1 got %h want %h", dq_in[1], mem_word(30'h0)); end
    end
  endtask

  task automatic test_redirect_wait();
    bit seen;
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    redirect_once(30'h20);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = out_valid && !out_stale && (out_addr == 30'h20);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rw_grant_timeout got none want grant for 20"); end
    redirect_once(30'h80);
    dq_pc.delete(); dq_in.delete();
    checks++;
    if (imem_addr !== 30'h80) begin errors++; $display("FAIL rw_addr got %h want 80", imem_addr); end
    for (int i = 0; i < 30 && dq_pc.size() < 1; i++) tick();
    checks++;
    if (dq_pc.size() < 1) begin
      errors++; $display("FAIL rw_timeout got 0 instrs want 1");
    end else begin
      checks += 2;
      if (dq_pc[0] !== 30'h80) begin errors++; $display("FAIL rw_pc got %h want 80", dq_pc[0]); end
      if (dq_in[0] !== mem_word(30'h80)) begin errors++; $display("FAIL rw_instr got %h want %h", dq_in[0], mem_word(30'h80)); end
    end
  endtask

  task automatic test_gnt_redirect();
    bit at5;
    gnt_pct = 0; lat_min = 1; lat_max = 1;
    redirect_once(30'h5);
    at5 = 1'b0;
    for (int i = 0; i < 20 && !at5; i++) begin
      at5 = (imem_req === 1'b1) && (imem_addr === 30'h5);
      if (!at5) tick();
    end
    checks++;
    if (!at5) begin errors++; $display("FAIL gr_setup got req=%0b addr=%h want req=1 addr=5", imem_req, imem_addr); end
    gnt_pct = 100;
    redirect_once(30'h40);
    dq_pc.delete(); dq_in.delete();
    checks++;
    if (imem_addr !== 30'h40) begin errors++; $display("FAIL gr_addr got %h want 40", imem_addr); end
    for (int i = 0; i < 30 && dq_pc.size() < 1; i++) tick();
    checks++;
    if (dq_pc.size() < 1) begin
      errors++; $display("FAIL gr_timeout got 0 instrs want 1");
    end else begin
      checks++;
      if (dq_pc[0] !== 30'h40) begin errors++; $display("FAIL gr_pc got %h want 40", dq_pc[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]  si;
    logic [N-1:0] sp;
    gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready = 1'b0;
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got valid=%0b want 1", instr_valid); end
    si = instr; sp = instr_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 4;
      if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", i, instr_valid); end
      if (instr !== si) begin errors++; $display("FAIL bp_instr[%0d] got %h want %h", i, instr, si); end
      if (instr_pc !== sp) begin errors++; $display("FAIL bp_pc[%0d] got %h want %h", i, instr_pc, sp); end
      if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d] got %0b want 0", i, imem_req); end
    end
    instr_ready = 1'b1;
    tick();
    checks += 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b want 0", instr_valid); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume_req got %0b want 1", imem_req); end
  endtask

  task automatic test_stall();
    logic [N-1:0] sa;
    gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    sa = imem_addr;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks += 2;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %0b want 0", i, imem_req); end
      if (imem_addr !== sa) begin errors++; $display("FAIL stall_pc[%0d] got %h want %h", i, imem_addr, sa); end
    end
    stall = 1'b0;
    #1;
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL unstall_req got %0b want 1", imem_req); end
    if (imem_addr !== exp_pc) begin errors++; $display("FAIL unstall_addr got %h want %h", imem_addr, exp_pc); end
  endtask

  task automatic test_mid_reset();
    bit inflight;
    gnt_pct = 100; lat_min = 3; lat_max = 3; stall = 1'b0; instr_ready = 1'b1;
    inflight = 1'b0;
    for (int i = 0; i < 20 && !inflight; i++) begin
      tick();
      inflight = out_valid && !out_stale;
    end
    checks++;
    if (!inflight) begin errors++; $display("FAIL mr_setup got no request want one in flight"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL mr_req got %0b want 0", imem_req); end
    if (imem_addr !== RPC) begin errors++; $display("FAIL mr_addr got %h want %h", imem_addr, RPC); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %0b want 0", instr_valid); end
    if (instr !== 32'h0) begin errors++; $display("FAIL mr_instr got %h want 0", instr); end
    if (instr_pc !== '0) begin errors++; $display("FAIL mr_instr_pc got %h want 0", instr_pc); end
    tick(); tick();
    rst_n = 1'b1;
    dq_pc.delete(); dq_in.delete();
    for (int i = 0; i < 30 && dq_pc.size() < 1; i++) tick();
    checks++;
    if (dq_pc.size() < 1) begin
      errors++; $display("FAIL mr_timeout got 0 instrs want 1");
    end else begin
      checks += 2;
      if (dq_pc[0] !== RPC) begin errors++; $display("FAIL mr_pc got %h want %h", dq_pc[0], RPC); end
      if (dq_in[0] !== mem_word(RPC)) begin errors++; $display("FAIL mr_instr_data got %h want %h", dq_in[0], mem_word(RPC)); end
    end
  endtask

  task automatic test_random();
    int start;
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    start = dq_pc.size();
    for (int i = 0; i < 3000; i++) begin
      stall          = (int'($urandom_range(99, 0)) < 20);
      instr_ready    = (int'($urandom_range(99, 0)) < 70);
      redirect_valid = (int'($urandom_range(99, 0)) < 6);
      redirect_addr  = $urandom_range(1, 0) ? 30'($urandom()) : 30'h3FFFFFFC + 30'($urandom_range(3, 0));
      #1;
      checks++;
      if (imem_req === 1'b1 && (stall || out_valid || holding)) begin
        errors++; $display("FAIL rnd_req[%0d] got 1 want 0 (stall=%0b busy=%0b)", i, stall, out_valid || holding);
      end
      tick();
      checks += 2;
      if (imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_addr, exp_pc); end
      if (instr_valid !== holding) begin errors++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, instr_valid, holding); end
      if (holding) begin
        checks += 2;
        if (instr_pc !== exp_ipc) begin errors++; $display("FAIL rnd_ipc[%0d] got %h want %h", i, instr_pc, exp_ipc); end
        if (instr !== mem_word(exp_ipc)) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", i, instr, mem_word(exp_ipc)); end
      end
    end
    redirect_valid = 1'b0; stall = 1'b0;
    checks++;
    if (dq_pc.size() - start < 100) begin
      errors++; $display("FAIL rnd_progress got %0d instrs want >=100", dq_pc.size() - start);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_redirect_wait();
    test_gnt_redirect();
    test_backpressure();
    test_stall();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Stage-1 program-counter and fetch sequencer for the RISC-V core. It owns the word-address PC register, issues one instruction-memory request at a time, and advances the PC by one word with wrap-around. It accepts branch/jump redirects from later stages and drops any fetch that a redirect makes stale. It presents fetched instructions to decode through a valid/ready handshake.

## Interface
- N, default 30: word-address width. Byte address is {pc, 2'b00}.
- RESET_PC, default 0: word address fetched first after reset (N bits).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  when 1, no new memory request is issued.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_addr  in  N  word-address target of the redirect.
- imem_req  out  1  memory request valid.
- imem_addr  out  N  word address of the request; equals the pc register.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid. Arrives 1+ cycles after gnt.
- imem_rdata  in  32  read data.
- instr_valid  out  1  instruction available to decode.
- instr  out  32  fetched instruction.
- instr_pc  out  N  word address of instr.
- instr_ready  in  1  decode accepts instr.

## Operation
- Reset state, entered asynchronously on rst_n=0:
  - state=BOOT, pc=RESET_PC, drop=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- BOOT: goes to REQ unconditionally on the first clock edge after rst_n rises.
- REQ: imem_req = !stall (combinational from state and stall).
  - gnt & !redirect: fetch_pc<=pc, pc<=pc+1 mod 2^N (all-ones wraps to 0), go to WAIT.
  - gnt & redirect: pc<=redirect_addr, drop<=1, go to WAIT. The granted request is stale.
  - !gnt & redirect: pc<=redirect_addr, stay in REQ. The address may change while req is high.
  - When stall=1, imem_gnt is ignored.
- WAIT: imem_req=0.
  - rvalid & (drop | redirect): discard the data, drop<=0, go to REQ. On redirect, pc<=redirect_addr.
  - rvalid, clean: instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1, go to HOLD.
  - redirect without rvalid: pc<=redirect_addr, drop<=1, stay in WAIT.
- HOLD: instr_valid=1, instr and instr_pc are stable, imem_req=0.
  - instr_ready: the transfer completes, instr_valid<=0, go to REQ.
  - redirect: instr_valid<=0, pc<=redirect_addr, go to REQ. If instr_ready is also 1, the transfer still counts; the redirect only sets the next pc.
- At most one outstanding memory transaction. rvalid outside WAIT is a protocol error and is ignored.
- The PC increment is N-bit modular with no carry out. Overflow is not flagged.

## Timing
- imem_addr, instr, instr_pc and instr_valid are registered. imem_req is combinational from state and stall.
- Best-case latency is gnt in the first REQ cycle and rvalid 1 cycle later:
  - Reset release to first imem_req is 1 cycle.
  - imem_req to instr_valid is 2 cycles.
  - Throughput is 1 instruction per 3 cycles with ready held at 1.
- A redirect takes effect on imem_addr at the next edge. The first request to the target is issued no later than 1 cycle after the stale response (if any) returns.
- rst_n assertion mid-transaction clears everything immediately. A late rvalid arriving after reset is ignored, because the state is BOOT or REQ.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_PC=0x10, memory gnt immediately and rvalid after 1 cycle, ready=1.
  - Required: instr_pc sequence 0x10, 0x11, 0x12, with matching instr.
  - Required: imem_req=0 during reset and during the first cycle.
- Wrap-around:
  - Stimulus: redirect to 0x3FFFFFFF (N=30).
  - Required: next fetches have instr_pc 0x3FFFFFFF, then 0x0.
- Redirect during WAIT:
  - Stimulus: request for 0x20 granted, redirect to 0x80 before rvalid.
  - Required: data for 0x20 never appears on instr_valid; next imem_addr=0x80; instr_pc=0x80.
- Simultaneous gnt and redirect in REQ:
  - Stimulus: gnt for 0x5 in the same cycle as redirect to 0x40.
  - Required: response dropped, next request is 0x40, no instruction with instr_pc=0x5.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles in HOLD.
  - Required: instr_valid=1 and instr/instr_pc stable; imem_req=0 throughout; fetch resumes 1 cycle after ready=1.
- Stall and mid-operation reset:
  - Stimulus: stall=1 in REQ.
  - Required: imem_req=0 and pc unchanged.
  - Stimulus: rst_n pulsed low in WAIT.
  - Required: all outputs return to reset values asynchronously, and the next fetch is from RESET_PC.
